bcd_conv_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one combinational `bin2bcd` double-dabble converter among N requesters. Sits between the lab's binary sources (counters, switch inputs, accumulators) and the 7-segment display drivers. It grants one requester at a time, registers its operand, and registers the converted BCD word. It then presents the result with the winner's ID on a valid/ready output channel.

---
 rtl/bcd_conv_arbiter.sv | 126 ++++++++++++
 tb/tb_bcd_conv_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_conv_arbiter.sv
// Round-robin arbiter sharing one combinational bin2bcd converter among N requesters.
// Grant -> operand register -> registered BCD result on a valid/ready channel.

module bin2bcd #(
    parameter int unsigned W  = 10,
    parameter int unsigned BW = W + (W - 4) / 3 + 1
) (
    input  logic [W-1:0]  bin,
    output logic [BW-1:0] bcd
);
    // Only full 4-bit digits need the add-3 step; a partial top digit never reaches 5.
    localparam int unsigned ND = BW / 4;

    logic [BW-1:0] acc;

    always_comb begin
        acc = '0;
        for (int i = int'(W) - 1; i >= 0; i--) begin
            for (int d = 0; d < int'(ND); d++) begin
                if (acc[4*d +: 4] >= 4'd5) begin
                    acc[4*d +: 4] = acc[4*d +: 4] + 4'd3;
                end
            end
            acc = {acc[BW-2:0], bin[i]};
        end
        bcd = acc;
    end
endmodule

module bcd_conv_arbiter #(
    parameter int unsigned W  = 10,
    parameter int unsigned N  = 4,
    parameter int unsigned BW = W + (W - 4) / 3 + 1,
    parameter int unsigned IW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    req,
    input  logic [N*W-1:0]  bin_in,
    output logic [N-1:0]    gnt,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [BW-1:0]   out_bcd,
    output logic [IW-1:0]   out_id,
    output logic            busy
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CONV = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [IW-1:0] ptr_q;
    logic [W-1:0]  op_q;
    logic [IW-1:0] id_q;
    logic [BW-1:0] conv_bcd;
    logic          found;
    logic [IW-1:0] win;
    logic          take;

    bin2bcd #(
        .W  (W),
        .BW (BW)
    ) u_bin2bcd (
        .bin (op_q),
        .bcd (conv_bcd)
    );

    // First requester at or after ptr, modulo N.
    always_comb begin
        int unsigned idx;
        idx   = 0;
        found = 1'b0;
        win   = '0;
        for (int unsigned off = 0; off < N; off++) begin
            idx = (32'(ptr_q) + off) % N;
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = IW'(idx);
            end
        end
    end

    assign take = (state_q == IDLE) && found;

    always_comb begin
        gnt = '0;
        if (take) begin
            gnt[win] = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (found) state_d = CONV;
            CONV:    state_d = HOLD;
            HOLD:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign out_valid = (state_q == HOLD);
    assign busy      = (state_q != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            op_q    <= '0;
            id_q    <= '0;
            out_bcd <= '0;
            out_id  <= '0;
        end else begin
            state_q <= state_d;
            if (take) begin
                op_q  <= bin_in[win*W +: W];
                id_q  <= win;
                ptr_q <= (win == IW'(N - 1)) ? '0 : win + IW'(1);
            end
            if (state_q == CONV) begin
                out_bcd <= conv_bcd;
                out_id  <= id_q;
            end
        end
    end
endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Directed bench for bcd_conv_arbiter: transaction-level model checked every cycle,
// plus literal expectations for conversions, grant order and timing.

module tb_bcd_conv_arbiter;
    localparam int W  = 10;
    localparam int N  = 4;
    localparam int BW = 13;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req = '0;
    logic [N*W-1:0]  bin_in = '0;
    logic [N-1:0]    gnt;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [BW-1:0]   out_bcd;
    logic [IW-1:0]   out_id;
    logic            busy;

    int n_cmp = 0;
    int n_bad = 0;

    bcd_conv_arbiter #(
        .W (W),
        .N (N)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .bin_in    (bin_in),
        .gnt       (gnt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bcd   (out_bcd),
        .out_id    (out_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [BW-1:0] to_bcd(input int v);
        int r;
        r = ((v / 1000) % 10) * 4096 + ((v / 100) % 10) * 256 + ((v / 10) % 10) * 16 + v % 10;
        return r[BW-1:0];
    endfunction

    // Model: one conversion in flight; result valid from two cycles after its grant.
    initial begin
        int          m_ptr;
        bit          in_flight;
        int          cyc;
        int          g_cyc;
        int          k;
        int          e_id;
        logic [N-1:0]  e_gnt;
        logic [BW-1:0] e_bcd;
        m_ptr = 0; in_flight = 0; cyc = 0; g_cyc = 0; e_id = 0; e_bcd = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                m_ptr = 0;
                in_flight = 0;
                check("rst_gnt", 32'(gnt), 0);
                check("rst_valid", 32'(out_valid), 0);
                check("rst_busy", 32'(busy), 0);
                check("rst_bcd", 32'(out_bcd), 0);
                check("rst_id", 32'(out_id), 0);
            end else begin
                k = -1;
                if (!in_flight) begin
                    for (int o = 0; o < N; o++) begin
                        if (k < 0 && req[(m_ptr + o) % N]) k = (m_ptr + o) % N;
                    end
                end
                e_gnt = '0;
                if (k >= 0) e_gnt[k] = 1'b1;
                check("m_gnt", 32'(gnt), 32'(e_gnt));
                check("m_busy", 32'(busy), 32'(in_flight && cyc > g_cyc));
                check("m_valid", 32'(out_valid), 32'(in_flight && cyc >= g_cyc + 2));
                if (in_flight && cyc >= g_cyc + 2) begin
                    check("m_bcd", 32'(out_bcd), 32'(e_bcd));
                    check("m_id", 32'(out_id), 32'(e_id));
                    if (out_ready) in_flight = 0;
                end
                if (k >= 0) begin
                    in_flight = 1;
                    g_cyc = cyc;
                    m_ptr = (k + 1) % N;
                    e_bcd = to_bcd(int'(bin_in[k*W +: W]));
                    e_id = k;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_gnt(input logic [N-1:0] exp, input string name, output int waited);
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (gnt == '0 && waited < 20);
        check(name, 32'(gnt), 32'(exp));
    endtask

    task automatic convert(input int k, input int val, input logic [BW-1:0] exp_bcd);
        int w;
        step();
        bin_in[k*W +: W] = W'(val);
        req = N'(1 << k);
        out_ready = 1'b1;
        wait_gnt(N'(1 << k), "cv_gnt", w);
        step();
        req = '0;
        @(negedge clk);
        @(negedge clk);
        check("cv_valid", 32'(out_valid), 1);
        check("cv_bcd", 32'(out_bcd), 32'(exp_bcd));
        check("cv_id", 32'(out_id), k);
        @(negedge clk);
        check("cv_idle", 32'(busy), 0);
    endtask

    int            tk[7] = '{0, 1, 2, 3, 0, 1, 3};
    int            tv[7] = '{999, 1023, 0, 1, 9, 10, 100};
    logic [BW-1:0] te[7] = '{13'h0999, 13'h1023, 13'h0000, 13'h0001, 13'h0009, 13'h0010,
                             13'h0100};

    initial begin
        int w;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Single conversions; the last one grants 3 so the pointer returns to 0.
        for (int i = 0; i < 7; i++) convert(tk[i], tv[i], te[i]);

        // Fairness with all four requesting continuously.
        step();
        bin_in = {10'd44, 10'd33, 10'd22, 10'd11};
        req = 4'b1111;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wait_gnt(N'(1 << (i % N)), "rr_order", w);
            if (i > 0) check("rr_period", w, 3);
        end
        step();
        req = '0;
        repeat (3) @(negedge clk);

        // Backpressure with requesters 1 and 2 waiting.
        step();
        out_ready = 1'b0;
        bin_in[0*W +: W] = 10'd555;
        req = 4'b0001;
        wait_gnt(4'b0001, "bp_gnt0", w);
        step();
        bin_in[1*W +: W] = 10'd123;
        bin_in[2*W +: W] = 10'd456;
        req = 4'b0110;
        @(negedge clk);
        @(negedge clk);
        repeat (10) begin
            check("bp_valid", 32'(out_valid), 1);
            check("bp_bcd", 32'(out_bcd), 32'h0555);
            check("bp_id", 32'(out_id), 0);
            check("bp_nognt", 32'(gnt), 0);
            @(negedge clk);
        end
        step();
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_hs_valid", 32'(out_valid), 1);
        wait_gnt(4'b0010, "bp_gnt1", w);
        check("bp_gnt1_lat", w, 1);
        step();
        req = 4'b0100;
        wait_gnt(4'b0100, "bp_gnt2", w);
        check("bp_gnt2_lat", w, 3);
        step();
        req = '0;
        repeat (3) @(negedge clk);

        // One-cycle request pulse from 2 while holding; the pointer must stay at 1.
        step();
        out_ready = 1'b0;
        bin_in[0*W +: W] = 10'd77;
        req = 4'b0001;
        wait_gnt(4'b0001, "wd_gnt0", w);
        step();
        req = '0;
        @(negedge clk);
        @(negedge clk);
        step();
        req = 4'b0100;
        @(negedge clk);
        check("wd_nognt", 32'(gnt), 0);
        step();
        req = '0;
        @(negedge clk);
        step();
        out_ready = 1'b1;
        @(negedge clk);
        step();
        req = 4'b1111;
        wait_gnt(4'b0010, "wd_ptr_kept", w);
        check("wd_lat", w, 1);
        step();
        req = '0;
        repeat (3) @(negedge clk);

        // Reset during CONV.
        step();
        bin_in[0*W +: W] = 10'd321;
        req = 4'b0001;
        wait_gnt(4'b0001, "rs_gnt0", w);
        step();
        req = '0;
        rst_n = 1'b0;
        #1;
        check("rs_valid", 32'(out_valid), 0);
        check("rs_busy", 32'(busy), 0);
        check("rs_gnt", 32'(gnt), 0);
        check("rs_bcd", 32'(out_bcd), 0);
        step();
        rst_n = 1'b1;
        req = 4'b0011;
        wait_gnt(4'b0001, "rs_ptr0", w);
        step();
        req = 4'b1000;
        wait_gnt(4'b1000, "rs_gnt3", w);
        check("rs_gnt3_lat", w, 3);
        step();
        req = '0;
        @(negedge clk);
        @(negedge clk);
        check("rs_bcd3", 32'(out_bcd), 32'h0044);
        check("rs_id3", 32'(out_id), 3);
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end
endmodule
